// File: rtl/ic_pkg.sv
// ic_pkg: shared definitions for the board-input conditioning block.
//   - deb_state_e : per-channel debounce FSM encoding
//   - *_DEF       : default geometry and timing constants
//   - BTN_*       : bit positions of the Nexys4 buttons inside btn_i/btn_o
//   - cnt_width() : width of the per-channel tick counter
package ic_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    ARM_HI  = 2'd1,
    HIGH    = 2'd2,
    ARM_LO  = 2'd3
  } deb_state_e;

  localparam int NBTN_DEF      = 5;
  localparam int NSW_DEF       = 16;
  localparam int TICK_DIV_DEF  = 1000;
  localparam int DEB_TICKS_DEF = 20;

  localparam int BTN_C = 0;
  localparam int BTN_D = 1;
  localparam int BTN_U = 2;
  localparam int BTN_R = 3;
  localparam int BTN_L = 4;

  // One spare bit so the counter can hold DEB_TICKS-1 for any DEB_TICKS.
  function automatic int cnt_width(input int deb_ticks);
    return $clog2(deb_ticks) + 1;
  endfunction

endpackage

// File: rtl/input_cond_if.sv
// input_cond_if: bundle of the raw board pins and the conditioned outputs.
//   master : board/environment side, drives btn_i/sw_i, observes the rest
//   slave  : input_cond, consumes btn_i/sw_i, drives the conditioned outputs
//   btn_i/sw_i          raw asynchronous pins
//   btn_o/sw_o          debounced levels
//   btn_press/release   one-cycle edge pulses of the debounced buttons
//   porti/portj         32-bit port words, zero-extended levels
//   tick                debounce tick strobe
interface input_cond_if
  import ic_pkg::*;
#(
  parameter int NBTN = NBTN_DEF,
  parameter int NSW  = NSW_DEF
);

  logic [NBTN-1:0] btn_i;
  logic [NSW-1:0]  sw_i;
  logic [NBTN-1:0] btn_o;
  logic [NBTN-1:0] btn_press;
  logic [NBTN-1:0] btn_release;
  logic [NSW-1:0]  sw_o;
  logic [31:0]     porti;
  logic [31:0]     portj;
  logic            tick;

  modport master (
    output btn_i, sw_i,
    input  btn_o, btn_press, btn_release, sw_o, porti, portj, tick
  );

  modport slave (
    input  btn_i, sw_i,
    output btn_o, btn_press, btn_release, sw_o, porti, portj, tick
  );

endinterface

// File: rtl/input_cond_deb_chan.sv
// deb_chan: one conditioned input channel.
//   clk, reset  : system clock, asynchronous active-high reset
//   raw_i       : raw asynchronous pin
//   tick_i      : shared debounce tick strobe
//   out_o       : debounced level (registered)
//   press_o     : one-cycle pulse in the first cycle out_o reads 1
//   release_o   : one-cycle pulse in the first cycle out_o reads 0
// A new level is accepted only after the synchronized input has disagreed
// with the current level for DEB_TICKS ticks in a row; any return to the
// old level in between abandons the attempt and the count restarts.
module deb_chan
  import ic_pkg::*;
#(
  parameter int DEB_TICKS = DEB_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  input  logic tick_i,
  output logic out_o,
  output logic press_o,
  output logic release_o
);

  localparam int             CW       = cnt_width(DEB_TICKS);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_TICKS - 1);

  logic          s1_q, s2_q;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE_LO: begin
        if (s2_q) begin
          state_d = ARM_HI;
          cnt_d   = '0;
        end
      end
      ARM_HI: begin
        // The abort check wins over a coincident tick.
        if (!s2_q) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (cnt_q == CNT_LAST) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HIGH: begin
        if (!s2_q) begin
          state_d = ARM_LO;
          cnt_d   = '0;
        end
      end
      ARM_LO: begin
        if (s2_q) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE_LO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase

    // Level follows the state being entered, so the pulses line up with the
    // first cycle the new level is visible.
    out_d     = (state_d == HIGH) || (state_d == ARM_LO);
    press_d   = out_d & ~out_q;
    release_d = ~out_d & out_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= IDLE_LO;
      cnt_q     <= '0;
      out_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= raw_i;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign out_o     = out_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/input_cond.sv
// input_cond: board-input conditioning for the Nexys4 test top.
//   clk    : system clock (the computer's clock domain)
//   reset  : asynchronous active-high reset, clears every register
//   bus    : input_cond_if.slave -- raw btn_i/sw_i in; debounced levels,
//            button press/release pulses, porti/portj words and tick out
// One shared tick divider feeds NBTN+NSW identical debounce channels.
// Switch channels produce pulses too, but nothing downstream wants them.
module input_cond
  import ic_pkg::*;
#(
  parameter int NBTN      = NBTN_DEF,
  parameter int NSW       = NSW_DEF,
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int DEB_TICKS = DEB_TICKS_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input_cond_if.slave   bus
);

  localparam int            DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0]   div_q, div_d;
  logic            tick;
  logic [NBTN-1:0] btn_lvl, btn_pr, btn_rl;
  logic [NSW-1:0]  sw_lvl;

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick = (div_q == DIV_LAST);

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    deb_chan #(.DEB_TICKS(DEB_TICKS)) u_chan (
      .clk       (clk),
      .reset     (reset),
      .raw_i     (bus.btn_i[g]),
      .tick_i    (tick),
      .out_o     (btn_lvl[g]),
      .press_o   (btn_pr[g]),
      .release_o (btn_rl[g])
    );
  end

  for (genvar g = 0; g < NSW; g++) begin : g_sw
    deb_chan #(.DEB_TICKS(DEB_TICKS)) u_chan (
      .clk       (clk),
      .reset     (reset),
      .raw_i     (bus.sw_i[g]),
      .tick_i    (tick),
      .out_o     (sw_lvl[g]),
      .press_o   (),
      .release_o ()
    );
  end

  assign bus.btn_o       = btn_lvl;
  assign bus.btn_press   = btn_pr;
  assign bus.btn_release = btn_rl;
  assign bus.sw_o        = sw_lvl;
  assign bus.porti       = 32'(btn_lvl);
  assign bus.portj       = 32'(sw_lvl);
  assign bus.tick        = tick;

endmodule

// File: tb/tb_input_cond.sv
module tb_input_cond;

  localparam int NBTN = 5;
  localparam int NSW  = 16;
  localparam int DIV  = 4;
  localparam int DEB  = 3;
  localparam int NCH  = NBTN + NSW;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  input_cond_if #(.NBTN(NBTN), .NSW(NSW)) bus ();

  input_cond #(
    .NBTN(NBTN), .NSW(NSW), .TICK_DIV(DIV), .DEB_TICKS(DEB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a channel accepts the opposite level once the
  // two-cycle-delayed input has disagreed with it for an unbroken run in
  // which DEB ticks occurred after the first disagreeing cycle.
  logic m_s1 [NCH];
  logic m_s2 [NCH];
  logic m_out[NCH];
  logic m_pr [NCH];
  logic m_rl [NCH];
  logic m_arm[NCH];
  int   m_ticks[NCH];
  int   m_div;

  function automatic void m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_out[c] = 0; m_pr[c] = 0; m_rl[c] = 0;
      m_arm[c] = 0; m_ticks[c] = 0;
    end
    m_div = 0;
  endfunction

  function automatic void m_step(input logic [NCH-1:0] raw);
    logic tk;
    tk = (m_div == DIV - 1);
    for (int c = 0; c < NCH; c++) begin
      m_pr[c] = 0;
      m_rl[c] = 0;
      if (m_s2[c] != m_out[c]) begin
        if (!m_arm[c]) begin
          m_arm[c]   = 1;
          m_ticks[c] = 0;
        end else if (tk) begin
          m_ticks[c]++;
          if (m_ticks[c] == DEB) begin
            m_out[c]   = !m_out[c];
            m_pr[c]    = m_out[c];
            m_rl[c]    = !m_out[c];
            m_arm[c]   = 0;
            m_ticks[c] = 0;
          end
        end
      end else begin
        m_arm[c]   = 0;
        m_ticks[c] = 0;
      end
      m_s2[c] = m_s1[c];
      m_s1[c] = raw[c];
    end
    m_div = (m_div == DIV - 1) ? 0 : m_div + 1;
  endfunction

  function automatic logic [127:0] m_obs();
    logic [NBTN-1:0] b, p, r;
    logic [NSW-1:0]  s;
    for (int c = 0; c < NBTN; c++) begin
      b[c] = m_out[c]; p[c] = m_pr[c]; r[c] = m_rl[c];
    end
    for (int c = 0; c < NSW; c++) s[c] = m_out[NBTN + c];
    return {b, p, r, s, 32'(b), 32'(s), (m_div == DIV - 1)};
  endfunction

  function automatic logic [127:0] dut_obs();
    return {bus.btn_o, bus.btn_press, bus.btn_release, bus.sw_o,
            bus.porti, bus.portj, bus.tick};
  endfunction

  int press_cnt[NBTN];
  int rel_cnt[NBTN];

  task automatic clr_cnts();
    for (int b = 0; b < NBTN; b++) begin
      press_cnt[b] = 0; rel_cnt[b] = 0;
    end
  endtask

  // Inputs are set just after a rising edge; the model consumes the same
  // values the DUT samples at the next edge.
  task automatic step();
    if (reset) m_reset();
    else       m_step({bus.sw_i, bus.btn_i});
    @(posedge clk);
    #1;
    chk("cycle", dut_obs(), m_obs());
    for (int b = 0; b < NBTN; b++) begin
      press_cnt[b] += int'(bus.btn_press[b]);
      rel_cnt[b]   += int'(bus.btn_release[b]);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Cycles until btn_o[idx] reads val, or 999 if it never does.
  task automatic wait_btn(input int idx, input logic val, output int n);
    n = 999;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus.btn_o[idx] === val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic async_reset_pulse();
    @(negedge clk);
    reset = 1'b1;
    m_reset();
    #1;
  endtask

  initial begin
    int          n;
    logic [11:0] tick_seen;
    logic [4:0]  rel_cap;

    reset      = 1'b1;
    bus.btn_i  = '0;
    bus.sw_i   = '0;
    m_reset();
    clr_cnts();

    // Reset with quiet inputs
    steps(3);
    chk("rst_porti", bus.porti, 32'h0);
    chk("rst_portj", bus.portj, 32'h0);
    reset = 1'b0;
    tick_seen = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      tick_seen[i] = bus.tick;
    end
    // div==3 in the 4th, 8th and 12th cycle after release
    chk("tick_phase", tick_seen, 12'h444);

    // Clean step on btnc
    clr_cnts();
    bus.btn_i[0] = 1'b1;
    wait_btn(0, 1'b1, n);
    chk("btn0_latency_ok", (n >= 11 && n <= 15), 1);
    steps(3);
    chk("btn0_press_once", press_cnt[0], 1);
    chk("btn0_porti", bus.porti, 32'h1);

    // Bouncing btnu, then settled
    clr_cnts();
    for (int i = 0; i < 40; i++) begin
      bus.btn_i[2] = ((i / 3) % 2) == 0;
      step();
    end
    chk("bounce_no_press", press_cnt[2], 0);
    bus.btn_i[2] = 1'b1;
    steps(25);
    chk("bounce_press_once", press_cnt[2], 1);

    // Switch pattern on and off
    clr_cnts();
    bus.sw_i = 16'hA5C3;
    steps(30);
    chk("portj_on", bus.portj, 32'h0000A5C3);
    chk("porti_unaffected", bus.porti, 32'h5);
    bus.sw_i = 16'h0;
    steps(30);
    chk("portj_off", bus.portj, 32'h0);
    chk("sw_no_btn_pulse", press_cnt[0] + press_cnt[2] + rel_cnt[0] + rel_cnt[2], 0);

    // Reset in ARM_HI and in HIGH with btnl held
    bus.btn_i = '0;
    steps(25);
    bus.btn_i[4] = 1'b1;
    steps(6);
    async_reset_pulse();
    chk("rst_in_arm_btn_o", bus.btn_o, 5'h0);
    steps(2);
    reset = 1'b0;
    clr_cnts();
    wait_btn(4, 1'b1, n);
    chk("rearm1_latency_ok", (n >= 11 && n <= 15), 1);
    steps(3);
    chk("rearm1_press_once", press_cnt[4], 1);
    async_reset_pulse();
    chk("rst_in_high_btn_o", bus.btn_o, 5'h0);
    chk("rst_in_high_pulses", {bus.btn_press, bus.btn_release}, 10'h0);
    steps(2);
    reset = 1'b0;
    clr_cnts();
    steps(20);
    chk("rearm2_press_once", press_cnt[4], 1);
    chk("rearm2_level", bus.btn_o[4], 1'b1);
    chk("rearm2_no_release", rel_cnt[4], 0);

    // All buttons released together
    bus.btn_i = 5'h1F;
    steps(25);
    chk("all_btn_high", bus.btn_o, 5'h1F);
    clr_cnts();
    bus.btn_i = 5'h00;
    rel_cap = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.btn_release != 0) begin
        rel_cap = bus.btn_release;
        break;
      end
    end
    chk("release_together", rel_cap, 5'h1F);
    steps(3);
    for (int b = 0; b < NBTN; b++) chk($sformatf("release_once_%0d", b), rel_cnt[b], 1);

    // Random activity on all channels
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        int c;
        c = $urandom_range(0, NCH - 1);
        if (c < NBTN) bus.btn_i[c] = ~bus.btn_i[c];
        else          bus.sw_i[c - NBTN] = ~bus.sw_i[c - NBTN];
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
